visualizador_hamming: RTL and testbench

Downstream display stage for the SECDED Hamming decoder. Latches the decoder's corrected 4-bit data, 3-bit syndrome and error flags on a capture strobe. Drives a 4-digit multiplexed 7-segment display and two error LEDs on the board. Digits: corrected data, syndrome, status code, and a spare digit.

---
 rtl/visualizador_hamming.sv | 159 +++++++++++++++
 tb/tb_visualizador_hamming.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/visualizador_hamming.sv
// 4-digit 7-segment / LED display stage for the SECDED Hamming decoder.
// Define ERROR_COUNT_EN to show a saturating error-capture count on digit 3.
module visualizador_hamming #(
   parameter int REFRESH_DIV = 50000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic       reloj,
   input  logic       rst_n,
   input  logic       captura,
   input  logic [3:0] dato,
   input  logic [2:0] sindrome,
   input  logic       error_simple,
   input  logic       error_doble,
   output logic [3:0] anodo,
   output logic [6:0] segmentos,
   output logic [1:0] led_error
);

   localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
   localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_DIV - 1);
   localparam logic [6:0] BLANK = 7'b1111111;

   logic [3:0]    dato_q, dato_d;
   logic [2:0]    sind_q, sind_d;
   logic          simple_q, simple_d;
   logic          doble_q, doble_d;
   logic [RW-1:0] ref_q, ref_d;
   logic [1:0]    idx_q, idx_d;
   logic [BW-1:0] blk_q, blk_d;
   logic          fase_q, fase_d;
   logic [3:0]    anodo_q, anodo_d;
   logic [6:0]    seg_q, seg_d;
   logic [1:0]    led_q, led_d;
`ifdef ERROR_COUNT_EN
   logic [3:0]    cnt_q, cnt_d;
`endif

   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      unique case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Holding registers and counters
   always_comb begin
      dato_d   = dato_q;
      sind_d   = sind_q;
      simple_d = simple_q;
      doble_d  = doble_q;
      if (captura) begin
         dato_d   = dato;
         sind_d   = sindrome;
         simple_d = error_simple;
         doble_d  = error_doble;
      end
      ref_d = ref_q + 1'b1;
      idx_d = idx_q;
      if (ref_q == REF_LAST) begin
         ref_d = '0;
         idx_d = idx_q + 2'd1;
      end
      blk_d  = blk_q + 1'b1;
      fase_d = fase_q;
      if (blk_q == BLK_LAST) begin
         blk_d  = '0;
         fase_d = ~fase_q;
      end
`ifdef ERROR_COUNT_EN
      cnt_d = cnt_q;
      if (captura && (error_simple || error_doble) && cnt_q != 4'hF)
         cnt_d = cnt_q + 4'd1;
`endif
   end

   // Outputs are driven from the current holding state, so a capture
   // shows up on the display one edge later.
   always_comb begin
      anodo_d = ~(4'b0001 << idx_q);
      seg_d   = BLANK;
      unique case (idx_q)
         2'd0: seg_d = hex7(dato_q);
         2'd1: seg_d = hex7({1'b0, sind_q});
         2'd2: begin
            if (doble_q)
               seg_d = fase_q ? BLANK : hex7(4'hD);
            else if (simple_q)
               seg_d = hex7(4'hE);
            else
               seg_d = hex7(4'h0);
         end
         default: begin
`ifdef ERROR_COUNT_EN
            seg_d = hex7(cnt_q);
`else
            seg_d = BLANK;
`endif
         end
      endcase
      led_d = doble_q ? 2'b10 : (simple_q ? 2'b01 : 2'b00);
   end

   always_ff @(posedge reloj) begin
      if (!rst_n) begin
         dato_q   <= '0;
         sind_q   <= '0;
         simple_q <= 1'b0;
         doble_q  <= 1'b0;
         ref_q    <= '0;
         idx_q    <= '0;
         blk_q    <= '0;
         fase_q   <= 1'b0;
         anodo_q  <= 4'b1111;
         seg_q    <= BLANK;
         led_q    <= 2'b00;
`ifdef ERROR_COUNT_EN
         cnt_q    <= '0;
`endif
      end else begin
         dato_q   <= dato_d;
         sind_q   <= sind_d;
         simple_q <= simple_d;
         doble_q  <= doble_d;
         ref_q    <= ref_d;
         idx_q    <= idx_d;
         blk_q    <= blk_d;
         fase_q   <= fase_d;
         anodo_q  <= anodo_d;
         seg_q    <= seg_d;
         led_q    <= led_d;
`ifdef ERROR_COUNT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   assign anodo     = anodo_q;
   assign segmentos = seg_q;
   assign led_error = led_q;

endmodule

// File: tb/tb_visualizador_hamming.sv
// Randomized self-checking bench for visualizador_hamming.
// Honours ERROR_COUNT_EN the same way the design does.
module tb_visualizador_hamming;

   localparam int RD = 4;
   localparam int BD = 16;
   localparam logic [6:0] SEG [0:15] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic       reloj = 1'b0;
   logic       rst_n = 1'b0;
   logic       captura = 1'b0;
   logic [3:0] dato = '0;
   logic [2:0] sindrome = '0;
   logic       error_simple = 1'b0;
   logic       error_doble = 1'b0;
   logic [3:0] anodo;
   logic [6:0] segmentos;
   logic [1:0] led_error;

   int vecs = 0;
   int errs = 0;

   // Reference model: what has been captured and edges since release
   int         e = 0;
   logic [3:0] m_dato = '0;
   logic [2:0] m_sind = '0;
   logic       m_es = 1'b0;
   logic       m_ed = 1'b0;
   int         m_cnt = 0;
   logic [12:0] exp_out;

   visualizador_hamming #(.REFRESH_DIV(RD), .BLINK_DIV(BD)) dut (
      .reloj(reloj), .rst_n(rst_n), .captura(captura),
      .dato(dato), .sindrome(sindrome),
      .error_simple(error_simple), .error_doble(error_doble),
      .anodo(anodo), .segmentos(segmentos), .led_error(led_error)
   );

   always #5 reloj = ~reloj;

   task automatic tick(input logic rst, input logic cap,
                       input logic [3:0] d, input logic [2:0] s,
                       input logic es, input logic ed);
      int idx;
      int ph;
      logic [6:0] sg;
      logic [3:0] an;
      logic [1:0] ld;
      rst_n = rst; captura = cap; dato = d;
      sindrome = s; error_simple = es; error_doble = ed;
      @(posedge reloj);
      #1;
      if (!rst) begin
         exp_out = {4'b1111, 7'b1111111, 2'b00};
         e = 0; m_dato = '0; m_sind = '0;
         m_es = 1'b0; m_ed = 1'b0; m_cnt = 0;
      end else begin
         idx = (e / RD) % 4;
         ph  = (e / BD) % 2;
         an  = 4'b1111 ^ (4'b0001 << idx);
         sg  = 7'b1111111;
         case (idx)
            0: sg = SEG[m_dato];
            1: sg = SEG[{1'b0, m_sind}];
            2: sg = m_ed ? ((ph == 1) ? 7'b1111111 : SEG[13])
                         : (m_es ? SEG[14] : SEG[0]);
            default: begin
`ifdef ERROR_COUNT_EN
               sg = SEG[m_cnt];
`else
               sg = 7'b1111111;
`endif
            end
         endcase
         ld = m_ed ? 2'b10 : (m_es ? 2'b01 : 2'b00);
         exp_out = {an, sg, ld};
         if (cap) begin
            m_dato = d; m_sind = s; m_es = es; m_ed = ed;
            if ((es || ed) && m_cnt < 15) m_cnt++;
         end
         e++;
      end
   endtask

   task automatic test_reset;
      for (int i = 0; i < 3; i++) begin
         tick(1'b0, 1'b1, 4'hF, 3'h7, 1'b1, 1'b1);
         vecs++;
         if ({anodo, segmentos, led_error} !== exp_out) begin
            errs++;
            $display("FAIL reset got %b exp %b",
                     {anodo, segmentos, led_error}, exp_out);
         end
      end
      tick(1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
      vecs++;
      if (anodo !== 4'b1110) begin
         errs++;
         $display("FAIL release_anodo got %b exp 1110", anodo);
      end
   endtask

   task automatic test_scan;
      for (int i = 0; i < 40; i++) begin
         tick(1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
         vecs++;
         if ({anodo, segmentos, led_error} !== exp_out) begin
            errs++;
            $display("FAIL scan got %b exp %b",
                     {anodo, segmentos, led_error}, exp_out);
         end
      end
   endtask

   task automatic test_clean;
      tick(1'b1, 1'b1, 4'h5, 3'h0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
         vecs++;
         if ({anodo, segmentos, led_error} !== exp_out) begin
            errs++;
            $display("FAIL clean got %b exp %b",
                     {anodo, segmentos, led_error}, exp_out);
         end
         if (anodo == 4'b1110) begin
            vecs++;
            if (segmentos !== 7'b0010010) begin
               errs++;
               $display("FAIL clean_d0 got %b exp 0010010", segmentos);
            end
         end
      end
   endtask

   task automatic test_single;
      tick(1'b1, 1'b1, 4'hA, 3'b101, 1'b1, 1'b0);
      vecs++;
      if (led_error !== 2'b00) begin
         errs++;
         $display("FAIL single_latency got %b exp 00", led_error);
      end
      tick(1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
      vecs++;
      if (led_error !== 2'b01) begin
         errs++;
         $display("FAIL single_led got %b exp 01", led_error);
      end
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
         vecs++;
         if ({anodo, segmentos, led_error} !== exp_out) begin
            errs++;
            $display("FAIL single got %b exp %b",
                     {anodo, segmentos, led_error}, exp_out);
         end
      end
   endtask

   task automatic test_double_blink;
      int lit = 0;
      int dark = 0;
      tick(1'b1, 1'b1, 4'h3, 3'b110, 1'b1, 1'b1);
      for (int i = 0; i < 80; i++) begin
         tick(1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
         vecs++;
         if ({anodo, segmentos, led_error} !== exp_out) begin
            errs++;
            $display("FAIL double got %b exp %b",
                     {anodo, segmentos, led_error}, exp_out);
         end
         if (anodo == 4'b1011 && segmentos == 7'b0100001) lit++;
         if (anodo == 4'b1011 && segmentos == 7'b1111111) dark++;
      end
      vecs++;
      if (lit == 0 || dark == 0 || led_error !== 2'b10) begin
         errs++;
         $display("FAIL blink lit=%0d dark=%0d led=%b exp both>0 led=10",
                  lit, dark, led_error);
      end
   endtask

   task automatic test_random;
      for (int i = 0; i < 400; i++) begin
         tick(1'b1, ($urandom_range(0, 3) == 0),
              4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
         vecs++;
         if ({anodo, segmentos, led_error} !== exp_out) begin
            errs++;
            $display("FAIL random got %b exp %b",
                     {anodo, segmentos, led_error}, exp_out);
         end
      end
   endtask

   task automatic test_count;
      logic [6:0] want;
      tick(1'b0, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
      for (int i = 0; i < 17; i++) begin
         tick(1'b1, 1'b1, 4'(i), 3'(i), 1'b1, i[0]);
         vecs++;
         if ({anodo, segmentos, led_error} !== exp_out) begin
            errs++;
            $display("FAIL count got %b exp %b",
                     {anodo, segmentos, led_error}, exp_out);
         end
      end
`ifdef ERROR_COUNT_EN
      want = 7'b0001110;
`else
      want = 7'b1111111;
`endif
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
         if (anodo == 4'b0111) begin
            vecs++;
            if (segmentos !== want) begin
               errs++;
               $display("FAIL count_d3 got %b exp %b", segmentos, want);
            end
         end
      end
      for (int i = 0; i < 6; i++)
         tick(1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
      vecs++;
      if ({anodo, segmentos, led_error} !== exp_out) begin
         errs++;
         $display("FAIL midreset got %b exp %b",
                  {anodo, segmentos, led_error}, exp_out);
      end
`ifdef ERROR_COUNT_EN
      want = 7'b1000000;
`endif
      for (int i = 0; i < 20; i++) begin
         tick(1'b1, 1'b0, 4'h0, 3'h0, 1'b0, 1'b0);
         vecs++;
         if ({anodo, segmentos, led_error} !== exp_out) begin
            errs++;
            $display("FAIL post_reset got %b exp %b",
                     {anodo, segmentos, led_error}, exp_out);
         end
         if (anodo == 4'b0111) begin
            vecs++;
            if (segmentos !== want) begin
               errs++;
               $display("FAIL cleared_d3 got %b exp %b", segmentos, want);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan();
      test_clean();
      test_single();
      test_double_blink();
      test_random();
      test_count();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
